// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter merging ALU and load writebacks into one regfile write port
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_we,
  output logic        wb_src,
  output logic [15:0] conflict_cnt
);

  // prio names the requester that wins the next conflict: 0=ALU, 1=load
  logic prio;
  logic both_valid;

  assign both_valid = alu_valid && ld_valid;

  always_comb begin
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    if (!rst) begin
      if (both_valid) begin
        alu_ready = !prio;
        ld_ready  = prio;
      end else begin
        alu_ready = alu_valid;
        ld_ready  = ld_valid;
      end
    end
  end

  // Writes to x0 are accepted and latched onto the port, but never enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_we   <= 1'b0;
      rd_addr <= 5'd0;
      rd_data <= 32'd0;
      wb_src  <= 1'b0;
      prio    <= 1'b0;
    end else begin
      rd_we <= 1'b0;
      if (alu_ready) begin
        rd_addr <= alu_rd;
        rd_data <= alu_data;
        wb_src  <= 1'b0;
        rd_we   <= |alu_rd;
        prio    <= 1'b1;
      end else if (ld_ready) begin
        rd_addr <= ld_rd;
        rd_data <= ld_data;
        wb_src  <= 1'b1;
        rd_we   <= |ld_rd;
        prio    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= 16'd0;
    end else if (both_valid && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_we;
  logic        wb_src;
  logic [15:0] conflict_cnt;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .ld_valid     (ld_valid),
    .ld_rd        (ld_rd),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_we        (rd_we),
    .wb_src       (wb_src),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_valid  = 1'b0; ld_rd  = 5'd0; ld_data  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_we", rd_we, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_wb_src", wb_src, 0);
    check("rst_cnt", conflict_cnt, 0);
    check("rst_alu_ready", alu_ready, 0);

    // single ALU transfer
    @(negedge clk);
    rst = 1'b0; alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hDEADBEEF;
    #1;
    check("single_alu_ready", alu_ready, 1);
    check("single_ld_ready", ld_ready, 0);
    @(posedge clk); #1;
    check("single_rd_we", rd_we, 1);
    check("single_rd_addr", rd_addr, 1);
    check("single_rd_data", rd_data, 32'hDEADBEEF);
    check("single_wb_src", wb_src, 0);
    @(negedge clk);
    alu_valid = 1'b0;
    #1;
    check("idle_alu_ready", alu_ready, 0);
    @(posedge clk); #1;
    check("idle_rd_we", rd_we, 0);
    check("idle_rd_addr_hold", rd_addr, 1);
    check("idle_rd_data_hold", rd_data, 32'hDEADBEEF);

    // alternating grants under conflict, starting from ALU after reset
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'hCAFEBABE;
    ld_valid  = 1'b1; ld_rd  = 5'd3; ld_data  = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_alu_ready", alu_ready, (i % 2 == 0) ? 1 : 0);
      check("rr_ld_ready", ld_ready, (i % 2 == 1) ? 1 : 0);
      @(posedge clk); #1;
      check("rr_rd_we", rd_we, 1);
      check("rr_wb_src", wb_src, (i % 2 == 1) ? 1 : 0);
      check("rr_rd_addr", rd_addr, (i % 2 == 1) ? 3 : 2);
      check("rr_rd_data", rd_data, (i % 2 == 1) ? 32'h12345678 : 32'hCAFEBABE);
      @(negedge clk);
    end
    check("rr_cnt", conflict_cnt, 4);

    // load to x0: accepted, no write enable
    alu_valid = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hFFFFFFFF;
    #1;
    check("x0_ld_ready", ld_ready, 1);
    check("x0_alu_ready", alu_ready, 0);
    @(posedge clk); #1;
    check("x0_rd_we", rd_we, 0);
    check("x0_wb_src", wb_src, 1);
    check("x0_rd_data", rd_data, 32'hFFFFFFFF);
    check("x0_cnt_hold", conflict_cnt, 4);

    // three load-only grants, then conflict goes to ALU
    @(negedge clk);
    ld_rd = 5'd4; ld_data = 32'h0000_00A5;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ldrun_ld_ready", ld_ready, 1);
      @(posedge clk); #1;
      check("ldrun_rd_we", rd_we, 1);
      check("ldrun_wb_src", wb_src, 1);
      @(negedge clk);
    end
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h5555_AAAA;
    #1;
    check("after_ld_alu_ready", alu_ready, 1);
    check("after_ld_ld_ready", ld_ready, 0);
    @(posedge clk); #1;
    check("after_ld_wb_src", wb_src, 0);
    check("after_ld_rd_addr", rd_addr, 5);
    check("after_ld_cnt", conflict_cnt, 5);

    // reset mid-stream with both valid
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_both_alu_ready", alu_ready, 0);
    check("rst_both_ld_ready", ld_ready, 0);
    @(posedge clk); #1;
    check("rst_both_rd_we", rd_we, 0);
    check("rst_both_cnt", conflict_cnt, 0);
    check("rst_both_rd_addr", rd_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_alu_ready", alu_ready, 1);
    check("post_rst_ld_ready", ld_ready, 0);
    @(posedge clk); #1;
    check("post_rst_wb_src", wb_src, 0);
    check("post_rst_rd_we", rd_we, 1);
    check("post_rst_cnt", conflict_cnt, 1);

    // counter saturation
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    check("sat_cnt_fffe", conflict_cnt, 32'h0000FFFE);
    @(posedge clk); #1;
    check("sat_cnt_ffff", conflict_cnt, 32'h0000FFFF);
    @(posedge clk); #1;
    check("sat_cnt_hold", conflict_cnt, 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port alu_valid, input, 1 bit: ALU writeback request present.
REQ-004 SHALL have port alu_rd, input, 5 bits: ALU destination register index.
REQ-005 SHALL have port alu_data, input, 32 bits: ALU writeback value.
REQ-006 SHALL have port alu_ready, output, 1 bit: ALU request accepted this cycle.
REQ-007 SHALL have port ld_valid, input, 1 bit: load writeback request present.
REQ-008 SHALL have port ld_rd, input, 5 bits: load destination register index.
REQ-009 SHALL have port ld_data, input, 32 bits: load writeback value.
REQ-010 SHALL have port ld_ready, output, 1 bit: load request accepted this cycle.
REQ-011 SHALL have port rd_addr, output, 5 bits: register file write address.
REQ-012 SHALL have port rd_data, output, 32 bits: register file write data.
REQ-013 SHALL have port rd_we, output, 1 bit: register file write enable.
REQ-014 SHALL have port wb_src, output, 1 bit: source of current write, 0=ALU, 1=load.
REQ-015 SHALL have port conflict_cnt, output, 16 bits: count of cycles with both requests valid.

Function
REQ-016 Transfer SHALL occur on a requester when its valid and ready are both high at a rising edge.
REQ-017 alu_ready and ld_ready SHALL be combinational from valids, priority pointer and rst; at most one SHALL be high per cycle.
REQ-018 Only one valid: that requester SHALL be granted (ready high) in the same cycle.
REQ-019 Both valid: requester named by priority pointer prio (0=ALU, 1=load) SHALL be granted; other SHALL see ready low.
REQ-020 After any grant, prio SHALL be set to the non-granted requester; with no grant, prio SHALL hold.
REQ-021 Neither valid: both readies low, no state change except REQ-024.
REQ-022 Latency: granted request SHALL appear on rd_addr/rd_data/wb_src exactly one cycle after the accepting edge, registered.
REQ-023 rd_we SHALL be high for exactly the one cycle following a transfer whose rd index is nonzero; transfer with rd=0 SHALL be accepted (ready high) but rd_we SHALL stay low.
REQ-024 Cycles with no transfer: rd_we low; rd_addr, rd_data, wb_src SHALL hold last value.
REQ-025 Back-to-back transfers SHALL be sustained at one per cycle with no bubble.
REQ-026 conflict_cnt SHALL increment by 1 every cycle alu_valid and ld_valid are both high, saturating at 16'hFFFF (no wrap).
REQ-027 Requester not granted SHALL be free to hold or change its request; arbiter SHALL keep no copy of ungranted requests.

Reset
REQ-028 While rst high, alu_ready and ld_ready SHALL be forced low; no transfer SHALL occur.
REQ-029 At rising edge with rst high: rd_we=0, rd_addr=0, rd_data=0, wb_src=0, conflict_cnt=0, prio=0 (ALU).
REQ-030 rst asserted mid-stream SHALL discard any transfer that edge; rd_we SHALL be 0 in the following cycle.
REQ-031 First cycle after rst deasserts SHALL arbitrate normally with prio=ALU.

Verification
REQ-032 Reset then alu_valid=1, alu_rd=1, alu_data=32'hDEADBEEF one cycle -> alu_ready=1 that cycle; next cycle rd_we=1, rd_addr=1, rd_data=32'hDEADBEEF, wb_src=0.
REQ-033 Both valid for 4 cycles (alu_rd=2/32'hCAFEBABE, ld_rd=3/32'h12345678) -> grants ALU, load, ALU, load; rd_we high 4 consecutive cycles; conflict_cnt=4.
REQ-034 ld_valid=1, ld_rd=0, ld_data=32'hFFFFFFFF -> ld_ready=1; next cycle rd_we=0, wb_src=1.
REQ-035 Preload conflict_cnt to 16'hFFFF via 65535 conflict cycles, then one more -> conflict_cnt stays 16'hFFFF.
REQ-036 Both valid with rst=1 -> both readies 0; next cycle rd_we=0, conflict_cnt=0; after rst drop, ALU granted first.
REQ-037 Single load only for 3 cycles then both valid -> load granted 3 times, then ALU granted (prio=ALU after load grants).
